rtc_write_ctrl: RTL and testbench

//  Write-side master for the RTC multiplexed address/data bus. Takes an 8-bit register

---
 rtl/rtc_bus_pkg.sv | 43 ++++
 rtl/rtc_write_ctrl_if.sv | 30 +++
 rtl/rtc_phase_timer.sv | 31 +++
 rtl/rtc_write_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rtc_write_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_bus_pkg.sv
// Purpose: shared definitions for the RTC multiplexed address/data bus controllers.
//   - idle pin levels for the RTC strobes and the address/data select
//   - default phase timing (clk cycles)
//   - write-controller state encoding
//   - helper to size phase timers
package rtc_bus_pkg;

   // Idle (inactive) pin levels
   localparam logic CS_IDLE = 1'b1;
   localparam logic WR_IDLE = 1'b1;
   localparam logic RD_IDLE = 1'b1;
   localparam logic AD_ADDR = 1'b1;  // a_d level that selects the address phase

   // Default phase timing, in clk cycles (each must be >= 1)
   localparam int unsigned T_SETUP_DEF = 2;
   localparam int unsigned T_PULSE_DEF = 4;
   localparam int unsigned T_HOLD_DEF  = 2;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StASet = 3'd1,
      StAWr  = 3'd2,
      StAHld = 3'd3,
      StDSet = 3'd4,
      StDWr  = 3'd5,
      StDHld = 3'd6,
      StFin  = 3'd7
   } wr_state_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Timer width able to hold the largest (N-1) load value; never below 1 bit.
   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
      return $clog2(max3(a, b, c)) + 1;
   endfunction

endpackage

// File: rtl/rtc_write_ctrl_if.sv
// Purpose: handshake and pin bundle between the control FSM, the RTC write controller
//   and the RTC pins.
//   start/in_addr/in_dato : write request from the control FSM
//   busy/done             : transaction status back to the control FSM
//   out_ad/ad_oe          : AD[7:0] value and its tristate enable
//   cs_n/a_d/wr_n/rd_n    : RTC control strobes
// Modports: master = the write controller, slave = its requester / pin consumer.
interface rtc_write_ctrl_if;
   logic       start;
   logic [7:0] in_addr;
   logic [7:0] in_dato;
   logic       busy;
   logic       done;
   logic [7:0] out_ad;
   logic       ad_oe;
   logic       cs_n;
   logic       a_d;
   logic       wr_n;
   logic       rd_n;

   modport master (
      input  start, in_addr, in_dato,
      output busy, done, out_ad, ad_oe, cs_n, a_d, wr_n, rd_n
   );

   modport slave (
      output start, in_addr, in_dato,
      input  busy, done, out_ad, ad_oe, cs_n, a_d, wr_n, rd_n
   );
endinterface

// File: rtl/rtc_phase_timer.sv
// Purpose: down-counting phase timer shared by the RTC read and write controllers.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset (count -> 0)
//   i_load     : load i_load_val this cycle (takes priority over counting)
//   i_load_val : N-1 for an N-cycle phase
//   o_zero     : count has reached 0, i.e. last cycle of the current phase
module rtc_phase_timer #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/rtc_write_ctrl.sv
// Purpose: write-side master for the RTC multiplexed address/data bus. One accepted start
//   drives a full write: address phase then data phase, each split into setup, WR strobe
//   and hold, followed by a one-cycle FIN with done=1.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : rtc_write_ctrl_if.master (start/in_addr/in_dato in; busy/done/out_ad/ad_oe/
//           cs_n/a_d/wr_n/rd_n out, all registered)
module rtc_write_ctrl
   import rtc_bus_pkg::*;
#(
   parameter int unsigned T_SETUP = T_SETUP_DEF,
   parameter int unsigned T_PULSE = T_PULSE_DEF,
   parameter int unsigned T_HOLD  = T_HOLD_DEF
) (
   input logic              clk,
   input logic              reset,
   rtc_write_ctrl_if.master bus
);

   localparam int unsigned TW = timer_width(T_SETUP, T_PULSE, T_HOLD);

   localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP - 1);
   localparam logic [TW-1:0] LD_PULSE = TW'(T_PULSE - 1);
   localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD - 1);

   wr_state_e r_state;
   logic [7:0] r_data;     // latched write byte; the address is held in r_out_ad
   logic       r_busy;
   logic       r_done;
   logic [7:0] r_out_ad;
   logic       r_ad_oe;
   logic       r_cs_n;
   logic       r_a_d;
   logic       r_wr_n;

   logic          w_load;
   logic [TW-1:0] w_load_val;
   logic          w_zero;

   // Reload the timer for the phase being entered on the same edge as the state change.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = LD_SETUP;
      unique case (r_state)
         StIdle: begin
            w_load     = bus.start;
            w_load_val = LD_SETUP;
         end
         StASet, StDSet: begin
            w_load     = w_zero;
            w_load_val = LD_PULSE;
         end
         StAWr, StDWr: begin
            w_load     = w_zero;
            w_load_val = LD_HOLD;
         end
         StAHld: begin
            w_load     = w_zero;
            w_load_val = LD_SETUP;
         end
         StDHld, StFin: begin
            w_load     = 1'b0;
         end
         default: begin
            w_load     = 1'b0;
         end
      endcase
   end

   rtc_phase_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   // Outputs are assigned alongside the state they belong to, so every pin is a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIdle;
         r_data   <= 8'h00;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_out_ad <= 8'h00;
         r_ad_oe  <= 1'b0;
         r_cs_n   <= CS_IDLE;
         r_a_d    <= AD_ADDR;
         r_wr_n   <= WR_IDLE;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (bus.start) begin
                  r_state  <= StASet;
                  r_data   <= bus.in_dato;
                  r_out_ad <= bus.in_addr;
                  r_busy   <= 1'b1;
                  r_ad_oe  <= 1'b1;
                  r_cs_n   <= ~CS_IDLE;
                  r_a_d    <= AD_ADDR;
                  r_wr_n   <= WR_IDLE;
               end
            end
            StASet: begin
               if (w_zero) begin
                  r_state <= StAWr;
                  r_wr_n  <= ~WR_IDLE;
               end
            end
            StAWr: begin
               if (w_zero) begin
                  r_state <= StAHld;
                  r_wr_n  <= WR_IDLE;
               end
            end
            StAHld: begin
               // Only place the bus switches from address to data; wr_n is high here.
               if (w_zero) begin
                  r_state  <= StDSet;
                  r_a_d    <= ~AD_ADDR;
                  r_out_ad <= r_data;
               end
            end
            StDSet: begin
               if (w_zero) begin
                  r_state <= StDWr;
                  r_wr_n  <= ~WR_IDLE;
               end
            end
            StDWr: begin
               if (w_zero) begin
                  r_state <= StDHld;
                  r_wr_n  <= WR_IDLE;
               end
            end
            StDHld: begin
               if (w_zero) begin
                  r_state  <= StFin;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_cs_n   <= CS_IDLE;
                  r_ad_oe  <= 1'b0;
                  r_a_d    <= AD_ADDR;
                  r_out_ad <= 8'h00;
               end
            end
            StFin: begin
               // start is deliberately not sampled here: forces one idle cycle.
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.out_ad = r_out_ad;
   assign bus.ad_oe  = r_ad_oe;
   assign bus.cs_n   = r_cs_n;
   assign bus.a_d    = r_a_d;
   assign bus.wr_n   = r_wr_n;
   assign bus.rd_n   = RD_IDLE;

endmodule

// File: tb/tb_rtc_write_ctrl.sv
// Testbench for rtc_write_ctrl: default-timing instance plus a 1/1/1-timing instance.
// Output vector layout: {busy, done, out_ad[7:0], ad_oe, cs_n, a_d, wr_n, rd_n}.
module tb_rtc_write_ctrl;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   localparam logic [14:0] IDLE_VEC = {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   rtc_write_ctrl_if if_def ();
   rtc_write_ctrl_if if_fast ();

   rtc_write_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (if_def)
   );

   rtc_write_ctrl #(
      .T_SETUP (1),
      .T_PULSE (1),
      .T_HOLD  (1)
   ) dut_fast (
      .clk   (clk),
      .reset (reset),
      .bus   (if_fast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] obs_def();
      return {if_def.busy, if_def.done, if_def.out_ad, if_def.ad_oe, if_def.cs_n,
              if_def.a_d, if_def.wr_n, if_def.rd_n};
   endfunction

   function automatic logic [14:0] obs_fast();
      return {if_fast.busy, if_fast.done, if_fast.out_ad, if_fast.ad_oe, if_fast.cs_n,
              if_fast.a_d, if_fast.wr_n, if_fast.rd_n};
   endfunction

   // Expected pins in cycle c after the accepting edge (c=1 is the first busy cycle).
   function automatic logic [14:0] exp_vec(input int c, input int ts, input int tp,
                                           input int th, input logic [7:0] a,
                                           input logic [7:0] d);
      int         p;
      int         q;
      logic       wr;
      logic       addr_ph;
      p = ts + tp + th;
      if (c >= 1 && c <= 2 * p) begin
         addr_ph = (c <= p);
         q       = addr_ph ? c : c - p;
         wr      = (q > ts && q <= ts + tp) ? 1'b0 : 1'b1;
         return {1'b1, 1'b0, (addr_ph ? a : d), 1'b1, 1'b0, addr_ph, wr, 1'b1};
      end else if (c == 2 * p + 1) begin
         return {1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      end
      return IDLE_VEC;
   endfunction

   // a_d/out_ad must stay put across consecutive cycles with wr_n low.
   logic       prev_wr_def  = 1'b1;
   logic       prev_ad_def  = 1'b1;
   logic [7:0] prev_out_def = 8'h00;
   logic       prev_wr_fst  = 1'b1;
   logic       prev_ad_fst  = 1'b1;
   logic [7:0] prev_out_fst = 8'h00;

   always @(negedge clk) begin
      if (!reset) begin
         if (!prev_wr_def && !if_def.wr_n) begin
            n_tests++;
            if (if_def.a_d !== prev_ad_def || if_def.out_ad !== prev_out_def) begin
               n_fail++;
               $display("FAIL stable_during_wr (def): a_d/out_ad got %b/%h required %b/%h",
                        if_def.a_d, if_def.out_ad, prev_ad_def, prev_out_def);
            end
         end
         if (!prev_wr_fst && !if_fast.wr_n) begin
            n_tests++;
            if (if_fast.a_d !== prev_ad_fst || if_fast.out_ad !== prev_out_fst) begin
               n_fail++;
               $display("FAIL stable_during_wr (fast): a_d/out_ad got %b/%h required %b/%h",
                        if_fast.a_d, if_fast.out_ad, prev_ad_fst, prev_out_fst);
            end
         end
      end
      prev_wr_def  = reset ? 1'b1 : if_def.wr_n;
      prev_ad_def  = if_def.a_d;
      prev_out_def = if_def.out_ad;
      prev_wr_fst  = reset ? 1'b1 : if_fast.wr_n;
      prev_ad_fst  = if_fast.a_d;
      prev_out_fst = if_fast.out_ad;
   end

   task automatic test_reset();
      logic [14:0] o;
      reset = 1'b1;
      if_def.start   = 1'b1;
      if_def.in_addr = 8'h77;
      if_def.in_dato = 8'h88;
      if_fast.start  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         o = obs_def();
         n_tests++;
         if (o !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL reset_def cyc %0d: got %h required %h", i, o, IDLE_VEC);
         end
         o = obs_fast();
         n_tests++;
         if (o !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL reset_fast cyc %0d: got %h required %h", i, o, IDLE_VEC);
         end
      end
      reset         = 1'b0;
      if_def.start  = 1'b0;
      if_fast.start = 1'b0;
      @(negedge clk);
      o = obs_def();
      n_tests++;
      if (o !== IDLE_VEC) begin
         n_fail++;
         $display("FAIL reset_release: got %h required %h", o, IDLE_VEC);
      end
   endtask

   task automatic test_single_write();
      logic [14:0] o;
      logic [14:0] e;
      int          wr_low = 0;
      int          busy_cnt = 0;
      @(negedge clk);
      if_def.in_addr = 8'h21;
      if_def.in_dato = 8'h59;
      if_def.start   = 1'b1;
      @(posedge clk);
      #1 if_def.start = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         o = obs_def();
         e = exp_vec(c, 2, 4, 2, 8'h21, 8'h59);
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL single_write cyc %0d: got %h required %h", c, o, e);
         end
         if (!if_def.wr_n) wr_low++;
         if (if_def.busy) busy_cnt++;
      end
      n_tests++;
      if (wr_low !== 8) begin
         n_fail++;
         $display("FAIL single_write wr_low_cycles: got %0d required 8", wr_low);
      end
      n_tests++;
      if (busy_cnt !== 16) begin
         n_fail++;
         $display("FAIL single_write busy_cycles: got %0d required 16", busy_cnt);
      end
   endtask

   task automatic test_input_change();
      logic [14:0] o;
      logic [14:0] e;
      @(negedge clk);
      if_def.in_addr = 8'h21;
      if_def.in_dato = 8'h59;
      if_def.start   = 1'b1;
      @(posedge clk);
      #1 if_def.start = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         o = obs_def();
         e = exp_vec(c, 2, 4, 2, 8'h21, 8'h59);
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL input_change cyc %0d: got %h required %h", c, o, e);
         end
         if (c == 4) begin
            if_def.in_dato = 8'hFF;
            if_def.in_addr = 8'h00;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [14:0] o;
      logic [14:0] e;
      int          dones = 0;
      @(negedge clk);
      if_def.in_addr = 8'hA1;
      if_def.in_dato = 8'hB2;
      if_def.start   = 1'b1;
      for (int c = 1; c <= 38; c++) begin
         @(negedge clk);
         o = obs_def();
         if (c <= 18)      e = exp_vec(c, 2, 4, 2, 8'hA1, 8'hB2);
         else if (c <= 35) e = exp_vec(c - 18, 2, 4, 2, 8'h5A, 8'hA5);
         else              e = IDLE_VEC;
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL back_to_back cyc %0d: got %h required %h", c, o, e);
         end
         if (if_def.done) dones++;
         if (c == 10) begin
            if_def.in_addr = 8'h5A;
            if_def.in_dato = 8'hA5;
         end
         if (c == 35) if_def.start = 1'b0;
      end
      n_tests++;
      if (dones !== 2) begin
         n_fail++;
         $display("FAIL back_to_back done_count: got %0d required 2", dones);
      end
   endtask

   task automatic test_start_while_busy();
      logic [14:0] o;
      logic [14:0] e;
      int          dones = 0;
      @(negedge clk);
      if_def.in_addr = 8'h3E;
      if_def.in_dato = 8'hE3;
      if_def.start   = 1'b1;
      @(posedge clk);
      #1 if_def.start = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         o = obs_def();
         e = exp_vec(c, 2, 4, 2, 8'h3E, 8'hE3);
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL start_while_busy cyc %0d: got %h required %h", c, o, e);
         end
         if (if_def.done) dones++;
         if_def.start = (c == 4 || c == 17);
      end
      if_def.start = 1'b0;
      n_tests++;
      if (dones !== 1) begin
         n_fail++;
         $display("FAIL start_while_busy done_count: got %0d required 1", dones);
      end
   endtask

   task automatic test_reset_mid();
      logic [14:0] o;
      logic [14:0] e;
      @(negedge clk);
      if_def.in_addr = 8'h44;
      if_def.in_dato = 8'h99;
      if_def.start   = 1'b1;
      @(posedge clk);
      #1 if_def.start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         o = obs_def();
         e = exp_vec(c, 2, 4, 2, 8'h44, 8'h99);
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid pre cyc %0d: got %h required %h", c, o, e);
         end
      end
      reset = 1'b1;
      for (int c = 13; c <= 16; c++) begin
         @(negedge clk);
         o = obs_def();
         n_tests++;
         if (o !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL reset_mid idle cyc %0d: got %h required %h", c, o, IDLE_VEC);
         end
         reset = 1'b0;
      end
      if_def.in_addr = 8'h0F;
      if_def.in_dato = 8'hF0;
      if_def.start   = 1'b1;
      @(posedge clk);
      #1 if_def.start = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         o = obs_def();
         e = exp_vec(c, 2, 4, 2, 8'h0F, 8'hF0);
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid post cyc %0d: got %h required %h", c, o, e);
         end
      end
   endtask

   task automatic test_fast_params();
      logic [14:0] o;
      logic [14:0] e;
      int          wr_low = 0;
      @(negedge clk);
      if_fast.in_addr = 8'h3C;
      if_fast.in_dato = 8'hC3;
      if_fast.start   = 1'b1;
      @(posedge clk);
      #1 if_fast.start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         o = obs_fast();
         e = exp_vec(c, 1, 1, 1, 8'h3C, 8'hC3);
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL fast_params cyc %0d: got %h required %h", c, o, e);
         end
         if (!if_fast.wr_n) wr_low++;
      end
      n_tests++;
      if (wr_low !== 2) begin
         n_fail++;
         $display("FAIL fast_params wr_low_cycles: got %0d required 2", wr_low);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      if_def.start    = 1'b0;
      if_def.in_addr  = 8'h00;
      if_def.in_dato  = 8'h00;
      if_fast.start   = 1'b0;
      if_fast.in_addr = 8'h00;
      if_fast.in_dato = 8'h00;

      test_reset();
      test_single_write();
      test_input_change();
      test_back_to_back();
      test_start_while_busy();
      test_reset_mid();
      test_fast_params();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
